// File: rtl/simple_cpu_pkg.sv
// ============================================================================
// Module   : simple_cpu_pkg
// Brief    : Shared SimpleCPU opcodes, instruction width and fetch states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package simple_cpu_pkg;

    localparam int INSTR_W = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OP_HALT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small prefetch FIFO with synchronous clear and a registered head.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import simple_cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DATA_W-1:0]        head_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && !clear_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i  && !clear_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
            // Head is the entry being pushed only when nothing older survives this cycle
            if (count_d == '0) begin
                head_d = '0;
            end else if (count_q == {{PTR_W{1'b0}}, do_pop}) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : SimpleCPU fetch stage: PC, single-outstanding memory reads,
//            prefetch buffering, HALT stop and flush redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import simple_cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    output logic              halted
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              resp_accept;
    logic              push;
    logic              pop;
    logic              has_space;
    logic              issue;

    // Responses arriving with nothing outstanding (e.g. after a reset) are ignored
    assign resp_accept = mem_rvalid && inflight_q;
    assign push        = resp_accept && !drop_q && !flush;
    assign pop         = out_valid && out_ready && !flush;
    assign has_space   = (fifo_count + CNT_W'(inflight_q)) < DEPTH_C;
    assign issue       = (state_q == ST_FETCH) && run && !inflight_q && !drop_q
                         && !flush && has_space;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;

        if (issue) begin
            inflight_d = 1'b1;
            pc_d       = pc_q + 1'b1;
        end
        if (resp_accept) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
        end

        case (state_q)
            ST_IDLE:   if (run)  state_d = ST_FETCH;
            ST_FETCH:  if (!run) state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        if (push && is_halt(mem_rdata)) begin
            state_d = ST_HALTED;
        end

        // An in-flight read not returning this cycle must be discarded when it does
        if (flush) begin
            pc_d    = flush_addr;
            drop_d  = inflight_q && !mem_rvalid;
            state_d = run ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (mem_rdata),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign mem_req   = issue;
    assign mem_addr  = issue ? pc_q : '0;
    assign out_valid = (fifo_count != '0);
    assign out_instr = fifo_head;
    assign halted    = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit with a
//            variable-latency memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       flush;
    logic [7:0] flush_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic [7:0] out_instr;
    logic       out_ready;
    logic       halted;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .flush      (flush),
        .flush_addr (flush_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_ready  (out_ready),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int         lat = 1;
    int         n_req = 0;
    int         overlap = 0;
    int         lat_err = 0;
    int         lat_seen = 0;
    int         dly = 0;
    logic       pend = 1'b0;
    logic       resp_now = 1'b0;
    logic       inject = 1'b0;
    logic       en_lat = 1'b0;
    logic       lat_arm = 1'b0;
    logic [7:0] pend_addr = 8'h00;
    logic [7:0] req_q [$];
    logic [7:0] got_q [$];
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model and monitor: observe mid-cycle, respond just after the edge
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (en_lat && lat_arm) begin
                    lat_seen++;
                    if (!out_valid) lat_err++;
                end
                lat_arm = mem_rvalid && resp_now && !flush;
                if (mem_req) begin
                    if (pend) overlap++;
                    n_req++;
                    req_q.push_back(mem_addr);
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                    dly       = lat;
                end
                if (out_valid && out_ready && !flush) got_q.push_back(out_instr);
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (reset_n !== 1'b1) begin
                pend     = 1'b0;
                resp_now = 1'b0;
            end else begin
                if (resp_now) begin
                    pend     = 1'b0;
                    resp_now = 1'b0;
                end
                if (inject) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 8'hEE;
                    inject     = 1'b0;
                end else if (pend) begin
                    dly--;
                    if (dly <= 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem[pend_addr];
                        resp_now   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h30 | 8'(i & 15);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        run        = 1'b0;
        flush      = 1'b0;
        flush_addr = 8'h00;
        out_ready  = 1'b0;
        inject     = 1'b0;
        en_lat     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        req_q.delete();
        got_q.delete();
        n_req    = 0;
        overlap  = 0;
        lat_err  = 0;
        lat_seen = 0;
        reset_n  = 1'b1;
    endtask

    task automatic wait_req(input int target, input int budget);
        int k = 0;
        while (n_req < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int k;
        int n55;
        run        = 1'b0;
        flush      = 1'b0;
        flush_addr = 8'h00;
        out_ready  = 1'b0;
        reset_n    = 1'b1;
        fill_mem();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", {24'd0, out_instr}, 32'd0);
        check("rst_halted",    {31'd0, halted},    32'd0);

        // Short program ending in HALT
        fill_mem();
        mem[0] = 8'h01; mem[1] = 8'h11; mem[2] = 8'hF0; mem[3] = 8'h22;
        lat = 1;
        do_reset();
        out_ready = 1'b1;
        run       = 1'b1;
        k = 0;
        while (!halted && k < 60) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        #1;
        check("halt_flag",    {31'd0, halted}, 32'd1);
        check("halt_n_req",   n_req, 32'd3);
        check("halt_addr0",   {24'd0, req_q[0]}, 32'h00);
        check("halt_addr1",   {24'd0, req_q[1]}, 32'h01);
        check("halt_addr2",   {24'd0, req_q[2]}, 32'h02);
        check("halt_n_got",   got_q.size(), 32'd3);
        check("halt_instr0",  {24'd0, got_q[0]}, 32'h01);
        check("halt_instr1",  {24'd0, got_q[1]}, 32'h11);
        check("halt_instr2",  {24'd0, got_q[2]}, 32'hF0);
        check("halt_drained", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("halt_async_rst", {31'd0, halted}, 32'd0);

        // Back-pressure: FIFO fills, then exactly one refill per pop
        fill_mem();
        lat = 1;
        do_reset();
        run = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("bp_n_req",     n_req, 32'd4);
        check("bp_req_idle",  {31'd0, mem_req}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head0",     {24'd0, out_instr}, 32'h30);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("bp_n_req_pop", n_req, 32'd5);
        check("bp_addr4",     {24'd0, req_q[4]}, 32'h04);
        check("bp_head1",     {24'd0, out_instr}, 32'h31);
        check("bp_n_got",     got_q.size(), 32'd1);
        check("bp_got0",      {24'd0, got_q[0]}, 32'h30);
        next_cycle();
        flush      = 1'b1;
        run        = 1'b0;
        flush_addr = 8'h80;
        @(negedge clk);
        #1;
        check("fl_full_req", {31'd0, mem_req}, 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        #1;
        check("fl_full_valid", {31'd0, out_valid}, 32'd0);
        check("fl_full_instr", {24'd0, out_instr}, 32'h00);

        // Three-cycle memory latency
        fill_mem();
        lat = 3;
        do_reset();
        out_ready = 1'b1;
        en_lat    = 1'b1;
        run       = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        en_lat = 1'b0;
        check("lat_overlap",  overlap, 32'd0);
        check("lat_errors",   lat_err, 32'd0);
        check("lat_samples",  {31'd0, lat_seen >= 5}, 32'd1);
        check("lat_got0",     {24'd0, got_q[0]}, 32'h30);
        check("lat_got1",     {24'd0, got_q[1]}, 32'h31);
        check("lat_got2",     {24'd0, got_q[2]}, 32'h32);

        // Flush with a read to 0x05 in flight
        fill_mem();
        mem[8'h05] = 8'h55; mem[8'h40] = 8'h12; mem[8'h41] = 8'h13;
        lat = 3;
        do_reset();
        flush      = 1'b1;
        flush_addr = 8'h05;
        next_cycle();
        flush     = 1'b0;
        out_ready = 1'b1;
        run       = 1'b1;
        wait_req(1, 40);
        check("fl_first_addr", {24'd0, req_q[0]}, 32'h05);
        next_cycle();
        flush      = 1'b1;
        flush_addr = 8'h40;
        @(negedge clk);
        #1;
        check("fl_req_in_flush", {31'd0, mem_req}, 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        #1;
        check("fl_valid_after", {31'd0, out_valid}, 32'd0);
        repeat (20) @(negedge clk);
        #1;
        check("fl_redirect_addr", {24'd0, req_q[1]}, 32'h40);
        check("fl_got0",          {24'd0, got_q[0]}, 32'h12);
        n55 = 0;
        foreach (got_q[i]) if (got_q[i] == 8'h55) n55++;
        check("fl_dropped", n55, 32'd0);

        // PC wrap from 0xFF
        fill_mem();
        mem[8'hFF] = 8'h21; mem[8'h00] = 8'h22;
        lat = 1;
        do_reset();
        flush      = 1'b1;
        flush_addr = 8'hFF;
        next_cycle();
        flush     = 1'b0;
        out_ready = 1'b1;
        run       = 1'b1;
        wait_req(2, 40);
        repeat (4) @(negedge clk);
        #1;
        check("wrap_addr0", {24'd0, req_q[0]}, 32'hFF);
        check("wrap_addr1", {24'd0, req_q[1]}, 32'h00);
        check("wrap_got0",  {24'd0, got_q[0]}, 32'h21);
        check("wrap_got1",  {24'd0, got_q[1]}, 32'h22);

        // Asynchronous reset with two buffered and one in flight
        fill_mem();
        lat = 1;
        do_reset();
        run = 1'b1;
        wait_req(3, 50);
        check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_valid",  {31'd0, out_valid}, 32'd0);
        check("mr_req",    {31'd0, mem_req},   32'd0);
        check("mr_halted", {31'd0, halted},    32'd0);
        check("mr_addr",   {24'd0, mem_addr},  32'd0);
        next_cycle();
        next_cycle();
        req_q.delete();
        got_q.delete();
        n_req     = 0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        inject    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("mr_spurious_ignored", {31'd0, out_valid}, 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("mr_first_addr", {24'd0, req_q[0]}, 32'h00);
        check("mr_got0",       {24'd0, got_q[0]}, 32'h30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
